// File: rtl/conv_buf_pkg.sv
// Shared defaults for the RAM-backed conv2 stream buffer.
// Holds word/address widths, RAM read latency and skid depth.
package conv_buf_pkg;
  localparam int DATA_W_D = 128;
  localparam int ADDR_W_D = 10;
  localparam int RD_LAT_D = 2;
  localparam int SKID_D_D = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rm_skid_fifo.sv
// Output skid FIFO with registered head entry (head = q[0]).
// Ports: clk, rst_n, clr, push/din, pop, head, cnt.
module rm_skid_fifo
  import conv_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = SKID_D_D,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     cnt
);

  logic [DATA_W-1:0] q [DEPTH];
  logic [PW-1:0]     widx;

  // Entries shift toward q[0] on pop, so the write slot
  // moves down by one when push and pop coincide.
  assign widx = PW'(pop ? cnt - 1'b1 : cnt);
  assign head = q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      if (push) q[widx] <= din;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/conv2_rm_ram_ctrl.sv
// In-order FIFO over an external simple dual-port RAM.
// Write port s_*, read port m_*, RAM ports ram_*, status level/empty/full.
module conv2_rm_ram_ctrl
  import conv_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int RD_LAT = RD_LAT_D,
  parameter int SKID_D = SKID_D_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = cnt_w(SKID_D);
  localparam logic [ADDR_W:0] FULL_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] SKID_N = (ADDR_W+1)'(SKID_D);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt, inflight, busy;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT:0]   vld_nxt;
  logic [CW-1:0]     skid_cnt;
  logic              wr, rd, pop;

  assign full      = ram_cnt == FULL_N;
  assign s_ready   = !full && !flush;
  assign wr        = s_valid && s_ready;
  assign ram_wea   = wr;
  assign ram_addra = wr_ptr;
  assign ram_dina  = s_data;
  assign ram_addrb = rd_ptr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + (ADDR_W+1)'(vld[i]);
  end

  // Reads are only issued when every in-flight word is
  // guaranteed a skid slot, so the skid can never overflow.
  assign busy    = inflight + (ADDR_W+1)'(skid_cnt);
  assign rd      = (ram_cnt != '0) && (busy < SKID_N) && !flush;
  assign vld_nxt = {vld, rd};
  assign m_valid = skid_cnt != '0;
  assign pop     = m_valid && m_ready;
  assign level   = busy + ram_cnt;
  assign empty   = level == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      vld     <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      vld     <= '0;
    end else begin
      vld <= vld_nxt[RD_LAT-1:0];
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  rm_skid_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (SKID_D)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .push (vld[RD_LAT-1]),
    .din  (ram_doutb),
    .pop  (pop),
    .head (m_data),
    .cnt  (skid_cnt)
  );

endmodule

// File: tb/tb_conv2_rm_ram_ctrl.sv
// Bench for conv2_rm_ram_ctrl: queue model, RAM model, directed cases.
// Ports all driven from initial block; monitor checks on negedge.
module tb_conv2_rm_ram_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         ram_wea;
  logic [9:0]   ram_addra;
  logic [127:0] ram_dina;
  logic [9:0]   ram_addrb;
  logic [127:0] ram_doutb;
  logic [10:0]  level;
  logic         empty;
  logic         full;

  int errors = 0;
  int checks = 0;
  int npop = 0;

  conv2_rm_ram_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb),
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  // RAM with two-cycle read latency
  logic [127:0] mem [1024];
  logic [127:0] rd_pipe;
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    rd_pipe   <= mem[ram_addrb];
    ram_doutb <= rd_pipe;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: words held = accepted minus popped, in order.
  logic [127:0] q [$];
  logic         stall = 1'b0;
  logic [127:0] stall_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall = 1'b0;
    end else begin
      chk("level", 128'(level), 128'(q.size()));
      chk("empty", 128'(empty), 128'(q.size() == 0));
      if (full && q.size() < 1024) chk("full_early", 128'(full), 128'(0));
      if (m_valid) begin
        if (q.size() == 0) chk("m_valid_spurious", 128'(m_valid), 128'(0));
        else chk("m_data", m_data, q[0]);
      end
      if (stall) begin
        chk("stall_valid", 128'(m_valid), 128'(1));
        chk("stall_data", m_data, stall_data);
      end
      stall = m_valid && !m_ready && !flush;
      stall_data = m_data;
      if (flush) q.delete();
      else begin
        if (m_valid && m_ready && q.size() > 0) begin
          void'(q.pop_front());
          npop++;
        end
        if (s_valid && s_ready) q.push_back(s_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] u;
    u = i;
    return {u ^ 32'hA5A5_0000, ~u, u * 32'd3, u};
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    while (!empty && n < 2000) begin
      step();
      n++;
    end
    chk(nm, 128'(empty), 128'(1));
  endtask

  task automatic lat_check(input string nm, input logic [127:0] d);
    int lat;
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    lat = 0;
    do begin
      step();
      s_valid = 1'b0;
      lat++;
    end while (!m_valid && lat < 10);
    chk({nm, "_lat"}, 128'(lat), 128'(4));
    chk({nm, "_data"}, m_data, d);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk({nm, "_empty"}, 128'(empty), 128'(1));
  endtask

  task automatic flush_case(input string nm, input int n);
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = pat(9000 + i);
      step();
    end
    flush   = 1'b1;
    s_data  = pat(9999);
    #1;
    chk({nm, "_sready"}, 128'(s_ready), 128'(0));
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk({nm, "_level"}, 128'(level), 128'(0));
    chk({nm, "_mvalid"}, 128'(m_valid), 128'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk({nm, "_late"}, 128'({m_valid, level}), 128'(0));
    end
    lat_check({nm, "_restart"}, pat(777 + n));
  endtask

  initial begin
    int nacc, n, p0;
    logic acc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvalid", 128'(m_valid), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_addrb", 128'(ram_addrb), 128'(0));
    chk("rst_mdata", m_data, 128'(0));
    rst_n = 1'b1;
    step();

    lat_check("first", {4{32'hA5A5_A5A5}});

    // 2000 words back-to-back, consumer always ready
    m_ready = 1'b1;
    nacc = 0;
    for (int i = 0; i < 2000; i++) begin
      s_valid = 1'b1;
      s_data  = pat(i);
      acc = s_ready;
      step();
      if (acc) nacc++;
    end
    s_valid = 1'b0;
    chk("stream_accepts", 128'(nacc), 128'(2000));
    n = 0;
    while (!empty && n < 20) begin
      step();
      n++;
    end
    chk("stream_drain_edges", 128'(n), 128'(4));

    // Fill RAM and skid completely
    m_ready = 1'b0;
    nacc = 0;
    n = 0;
    while (nacc < 1028 && n < 3000) begin
      s_valid = 1'b1;
      s_data  = pat(5000 + nacc);
      acc = s_ready;
      step();
      if (acc) nacc++;
      n++;
    end
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_sready", 128'(s_ready), 128'(0));
    chk("fill_level", 128'(level), 128'(1028));
    step();
    chk("fill_hold_level", 128'(level), 128'(1028));
    p0 = npop;
    drain("fill_drain");
    chk("fill_popped", 128'(npop - p0), 128'(1028));

    // Random stalls on both sides
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom % 100) < 70;
      s_data  = {$urandom, $urandom, $urandom, $urandom};
      m_ready = ($urandom % 100) >= 30;
      step();
    end
    drain("rand_drain");

    flush_case("flush3", 3);
    flush_case("flush6", 6);

    // Reset mid-stream
    m_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_valid = 1'b1;
      s_data  = pat(20000 + i);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 128'(m_valid), 128'(0));
    chk("arst_level", 128'(level), 128'(0));
    chk("arst_empty", 128'(empty), 128'(1));
    chk("arst_full", 128'(full), 128'(0));
    chk("arst_addrb", 128'(ram_addrb), 128'(0));
    chk("arst_mdata", m_data, 128'(0));
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    lat_check("post_rst", pat(31337));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
